// File: rtl/key_event_unit.sv
// key_event_unit: push-button front end on an Avalon-MM slave port.
// Per-key two-flop synchronisation and debounce, press/release edge-capture
// registers with write-1-to-clear, and a maskable registered level interrupt.
module key_event_unit #(
    parameter int N_KEYS          = 3,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] keys_n,
    input  logic [1:0]        address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_KEYS-1:0] key_p0;
    logic [N_KEYS-1:0] key_p1;
    logic [N_KEYS-1:0] key_s;
    logic [CNT_W-1:0]  cnt [N_KEYS];
    logic [N_KEYS-1:0] stable;
    logic [N_KEYS-1:0] accept;
    logic [N_KEYS-1:0] press_evt;
    logic [N_KEYS-1:0] release_evt;
    logic [N_KEYS-1:0] mask_p;
    logic [N_KEYS-1:0] mask_r;
    logic [N_KEYS-1:0] press_cap;
    logic [N_KEYS-1:0] release_cap;
    logic [N_KEYS-1:0] clr_press;
    logic [N_KEYS-1:0] clr_release;
    logic              wr_mask;
    logic [31:0]       rd_mux;
    logic              unused_wd;

    // Synchroniser stages hold the raw active-low pin level (released = 1 on reset).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_p0 <= '1;
            key_p1 <= '1;
        end else begin
            key_p0 <= keys_n;
            key_p1 <= key_p0;
        end
    end

    assign key_s = ~key_p1;

    // A new level is accepted on the edge where it has been seen for DEBOUNCE_CYCLES edges.
    always_comb begin
        accept = '0;
        for (int k = 0; k < N_KEYS; k++) begin
            accept[k] = (key_s[k] != stable[k]) && (cnt[k] == CNT_MAX);
        end
    end

    assign press_evt   = accept & ~stable;
    assign release_evt = accept & stable;

    // Debounce counters restart on any return to the stable level and on acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N_KEYS; k++) begin
                cnt[k] <= '0;
            end
            stable <= '0;
        end else begin
            for (int k = 0; k < N_KEYS; k++) begin
                if ((key_s[k] == stable[k]) || accept[k]) begin
                    cnt[k] <= '0;
                end else begin
                    cnt[k] <= cnt[k] + 1'b1;
                end
            end
            stable <= stable ^ accept;
        end
    end

    assign wr_mask     = write && (address == 2'd1);
    assign clr_press   = (write && (address == 2'd2)) ? writedata[N_KEYS-1:0] : '0;
    assign clr_release = (write && (address == 2'd3)) ? writedata[N_KEYS-1:0] : '0;
    assign unused_wd   = ^writedata;

    // Mask and capture registers; a capture event beats a clear on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_p      <= '0;
            mask_r      <= '0;
            press_cap   <= '0;
            release_cap <= '0;
        end else begin
            if (wr_mask) begin
                mask_p <= writedata[N_KEYS-1:0];
                mask_r <= writedata[16 +: N_KEYS];
            end
            press_cap   <= (press_cap & ~clr_press) | press_evt;
            release_cap <= (release_cap & ~clr_release) | release_evt;
        end
    end

    // Read data selection; unused bits read as zero.
    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0: rd_mux[N_KEYS-1:0] = stable;
            2'd1: begin
                rd_mux[N_KEYS-1:0]   = mask_p;
                rd_mux[16 +: N_KEYS] = mask_r;
            end
            2'd2:    rd_mux[N_KEYS-1:0] = press_cap;
            default: rd_mux[N_KEYS-1:0] = release_cap;
        endcase
    end

    // Registered read port (one cycle latency) and registered interrupt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            if (read) begin
                readdata <= rd_mux;
            end
            irq <= |((press_cap & mask_p) | (release_cap & mask_r));
        end
    end

endmodule

// File: tb/tb_key_event_unit.sv
// Testbench for key_event_unit: directed corner-case sequences, a register
// access vector table, and randomized traffic against a history-window model.
module tb_key_event_unit;
    localparam int N = 3;
    localparam int D = 4;
    localparam logic [31:0] MASK_BITS = 32'h0007_0007;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  keys_n;
    logic [1:0]    address;
    logic          read;
    logic          write;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic          irq;

    always #5 clk = ~clk;

    key_event_unit #(.N_KEYS(N), .DEBOUNCE_CYCLES(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .keys_n    (keys_n),
        .address   (address),
        .read      (read),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pressed-level history per key, newest sample at index 0.
    logic         hist [N][D+2];
    logic [N-1:0] m_stable;
    logic [N-1:0] m_press;
    logic [N-1:0] m_rel;
    logic [31:0]  m_mask;
    logic [31:0]  m_rd;
    logic         m_irq;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  a;
        logic [31:0] wd;
        logic        chk_data;
        logic [31:0] exp_data;
        logic        exp_irq;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++)
            for (int j = 0; j < D + 2; j++)
                hist[k][j] = 1'b0;
        m_stable = '0;
        m_press  = '0;
        m_rel    = '0;
        m_mask   = '0;
        m_rd     = '0;
        m_irq    = 1'b0;
    endtask

    function automatic logic [31:0] reg_value(input logic [1:0] a);
        case (a)
            2'd0:    return 32'(m_stable);
            2'd1:    return m_mask;
            2'd2:    return 32'(m_press);
            default: return 32'(m_rel);
        endcase
    endfunction

    // One clock cycle of bus activity, with the model advanced alongside.
    task automatic cycle(input logic r, input logic w, input logic [1:0] a, input logic [31:0] wd);
        logic [N-1:0] rise;
        logic [N-1:0] fall;
        logic         all_diff;
        read      = r;
        write     = w;
        address   = a;
        writedata = wd;
        if (r) m_rd = reg_value(a);
        m_irq = |((m_press & m_mask[N-1:0]) | (m_rel & m_mask[16 +: N]));
        rise = '0;
        fall = '0;
        for (int k = 0; k < N; k++) begin
            for (int j = D + 1; j > 0; j--) hist[k][j] = hist[k][j-1];
            hist[k][0] = ~keys_n[k];
            // The debounce sees the pin two edges late; accept after D differing samples.
            all_diff = 1'b1;
            for (int j = 2; j < D + 2; j++)
                if (hist[k][j] == m_stable[k]) all_diff = 1'b0;
            if (all_diff) begin
                if (m_stable[k]) fall[k] = 1'b1;
                else             rise[k] = 1'b1;
                m_stable[k] = ~m_stable[k];
            end
        end
        if (w && a == 2'd1) m_mask = wd & MASK_BITS;
        if (w && a == 2'd2) m_press = m_press & ~wd[N-1:0];
        if (w && a == 2'd3) m_rel   = m_rel & ~wd[N-1:0];
        m_press = m_press | rise;
        m_rel   = m_rel | fall;
        @(posedge clk);
        #1;
        read  = 1'b0;
        write = 1'b0;
        check("model_irq", 32'(irq), 32'(m_irq));
        if (r) check("model_readdata", readdata, m_rd);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'b0, 2'd0, 32'd0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cycle(1'b0, 1'b1, a, d);
    endtask

    task automatic rd(input logic [1:0] a);
        cycle(1'b1, 1'b0, a, 32'd0);
    endtask

    // Asynchronous reset pulse between edges; released 1 time unit after an edge.
    task automatic apply_reset();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("reset_readdata", readdata, 32'd0);
        check("reset_irq", 32'(irq), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b1, 2'd1, 32'hFFFF_FFFF, 1'b0, 32'd0,          1'b0};
        vecs[1] = '{1'b1, 1'b0, 2'd1, 32'd0,         1'b1, 32'h0007_0007,  1'b1};
        vecs[2] = '{1'b0, 1'b1, 2'd0, 32'hFFFF_FFFF, 1'b0, 32'd0,          1'b1};
        vecs[3] = '{1'b1, 1'b0, 2'd0, 32'd0,         1'b1, 32'h0000_0001,  1'b1};
        vecs[4] = '{1'b0, 1'b1, 2'd2, 32'hFFFF_FFFF, 1'b0, 32'd0,          1'b1};
        vecs[5] = '{1'b1, 1'b0, 2'd2, 32'd0,         1'b1, 32'd0,          1'b0};
        vecs[6] = '{1'b0, 1'b1, 2'd1, 32'd0,         1'b0, 32'd0,          1'b0};
        vecs[7] = '{1'b1, 1'b0, 2'd1, 32'd0,         1'b1, 32'd0,          1'b0};
        vecs[8] = '{1'b1, 1'b0, 2'd3, 32'd0,         1'b1, 32'd0,          1'b0};

        reset     = 1'b1;
        keys_n    = '1;
        address   = 2'd0;
        read      = 1'b0;
        write     = 1'b0;
        writedata = 32'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("init_readdata", readdata, 32'd0);
        check("init_irq", 32'(irq), 32'd0);
        reset = 1'b0;
        idle(3);

        // Clean press of key 0: LEVEL and PRESS_CAP on edge 6, irq on edge 7.
        wr(2'd1, 32'h1);
        keys_n[0] = 1'b0;
        idle(5);
        rd(2'd0);
        check("t1_level_edge6", readdata, 32'd0);
        check("t1_irq_edge6", 32'(irq), 32'd0);
        rd(2'd0);
        check("t1_level_after", readdata, 32'd1);
        check("t1_irq_edge7", 32'(irq), 32'd1);
        rd(2'd2);
        check("t1_press_cap", readdata, 32'd1);

        // Bounced key 1: 3-cycle low pulses never accepted; final hold accepted once.
        wr(2'd2, 32'h7);
        for (int p = 0; p < 3; p++) begin
            keys_n[1] = 1'b0;
            repeat (3) begin
                rd(2'd2);
                check("t2_bounce_press", 32'(readdata[1]), 32'd0);
            end
            keys_n[1] = 1'b1;
            rd(2'd2);
            check("t2_bounce_press", 32'(readdata[1]), 32'd0);
        end
        keys_n[1] = 1'b0;
        idle(5);
        rd(2'd2);
        check("t2_press_edge6", readdata, 32'd0);
        rd(2'd2);
        check("t2_press_after", readdata, 32'h2);
        rd(2'd3);
        check("t2_no_release", readdata, 32'd0);

        // Key 2 press/release with only its release interrupt enabled.
        keys_n = '1;
        idle(8);
        wr(2'd2, 32'h7);
        wr(2'd3, 32'h7);
        wr(2'd1, 32'h0004_0000);
        keys_n[2] = 1'b0;
        idle(8);
        rd(2'd2);
        check("t3_press_cap", readdata, 32'h4);
        check("t3_irq_press", 32'(irq), 32'd0);
        keys_n[2] = 1'b1;
        idle(8);
        rd(2'd3);
        check("t3_release_cap", readdata, 32'h4);
        check("t3_irq_release", 32'(irq), 32'd1);
        wr(2'd3, 32'h4);
        check("t3_irq_at_clear", 32'(irq), 32'd1);
        idle(1);
        check("t3_irq_cleared", 32'(irq), 32'd0);

        // Clear and new key-0 press on the same edge: the event wins.
        wr(2'd2, 32'h7);
        keys_n[0] = 1'b0;
        idle(5);
        wr(2'd2, 32'h1);
        rd(2'd2);
        check("t4_event_wins", readdata, 32'h1);
        wr(2'd2, 32'h1);
        rd(2'd2);
        check("t4_clear_works", readdata, 32'd0);

        // Reset mid-count with key 0 held; press accepted 6 edges after release.
        keys_n[0] = 1'b1;
        idle(8);
        wr(2'd3, 32'h7);
        keys_n[0] = 1'b0;
        idle(4);
        apply_reset();
        rd(2'd0);
        check("t5_level", readdata, 32'd0);
        rd(2'd1);
        check("t5_mask", readdata, 32'd0);
        rd(2'd2);
        check("t5_press_e3", readdata, 32'd0);
        rd(2'd3);
        check("t5_release", readdata, 32'd0);
        rd(2'd2);
        check("t5_press_e5", readdata, 32'd0);
        rd(2'd2);
        check("t5_press_e6", readdata, 32'd0);
        rd(2'd2);
        check("t5_press_after", readdata, 32'h1);

        // Register access table with key 0 held and accepted.
        for (int i = 0; i < 9; i++) begin
            cycle(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].wd);
            if (vecs[i].chk_data) check($sformatf("vec%0d_data", i), readdata, vecs[i].exp_data);
            check($sformatf("vec%0d_irq", i), 32'(irq), 32'(vecs[i].exp_irq));
        end

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            int sel;
            for (int k = 0; k < N; k++)
                if ($urandom_range(7) == 0) keys_n[k] = ~keys_n[k];
            if ($urandom_range(399) == 0) apply_reset();
            sel = int'($urandom_range(11));
            case (sel)
                0, 1, 2, 3: rd(2'($urandom_range(3)));
                4:          wr(2'd1, $urandom);
                5:          wr(2'd2, $urandom);
                6:          wr(2'd3, $urandom);
                7:          wr(2'd0, $urandom);
                default:    idle(1);
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
